// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns a 256-bit dcache line read/write into a 4-beat 64-bit memory burst.
// Latency: a request seen in IDLE at T drives read_o/write_o from T+1; pmem_resp 1 cycle after the 4th resp_i.
// Backpressure: memory stalls by withholding resp_i (beat count holds, no timeout); cache holds its request until pmem_resp.
// Optional feature: define CLA_POSTED_WRITE_EN to acknowledge writes at T+1 and run the burst in the background.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [1:0]    r_cnt;
  logic [31:0]   r_addr;
  logic [191:0]  r_rbuf;    // beats 0..2 of the line in flight; beat 3 goes straight to r_rdata
  logic [255:0]  r_rdata;   // last completed read line, only updated when a read finishes
  logic [255:0]  r_wbuf;
  logic          r_read;
  logic          r_write;
  logic          r_resp;
`ifdef CLA_POSTED_WRITE_EN
  logic          r_posted;  // current WRITE burst was already acknowledged to the cache
`endif

  // Offset bits of the line address carry no information for a line-granular port.
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = &{1'b0, pmem_address[4:0]};

  // Current write beat is selected from the latched line by the beat counter.
  logic [7:0] w_wofs;
  assign w_wofs = {r_cnt, 6'b0};

  assign burst_o    = r_wbuf[w_wofs +: 64];
  assign pmem_rdata = r_rdata;
  assign pmem_resp  = r_resp;
  assign address_o  = r_addr;
  assign read_o     = r_read;
  assign write_o    = r_write;

  // Request/burst sequencer; strobes are registered alongside the state so they follow it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_addr   <= 32'd0;
      r_rbuf   <= 192'd0;
      r_rdata  <= 256'd0;
      r_wbuf   <= 256'd0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_resp   <= 1'b0;
`ifdef CLA_POSTED_WRITE_EN
      r_posted <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // Write takes priority if both requests are raised together.
          if (pmem_write) begin
            r_addr <= {pmem_address[31:5], 5'b0};
            r_wbuf <= pmem_wdata;
            r_cnt  <= 2'd0;
`ifdef CLA_POSTED_WRITE_EN
            r_posted <= 1'b1;
            r_resp   <= 1'b1;
            r_state  <= S_DONE;
`else
            r_write  <= 1'b1;
            r_state  <= S_WRITE;
`endif
          end else if (pmem_read) begin
            r_addr  <= {pmem_address[31:5], 5'b0};
            r_cnt   <= 2'd0;
            r_read  <= 1'b1;
            r_state <= S_READ;
          end
        end

        S_READ: begin
          if (resp_i) begin
            r_cnt <= r_cnt + 2'd1;
            case (r_cnt)
              2'd0: r_rbuf[63:0]    <= burst_i;
              2'd1: r_rbuf[127:64]  <= burst_i;
              2'd2: r_rbuf[191:128] <= burst_i;
              default: begin
                r_rdata <= {burst_i, r_rbuf};
                r_read  <= 1'b0;
                r_resp  <= 1'b1;
                r_state <= S_DONE;
              end
            endcase
          end
        end

        S_WRITE: begin
          if (resp_i) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_write <= 1'b0;
`ifdef CLA_POSTED_WRITE_EN
              if (r_posted) begin
                // Already acknowledged at acceptance: no second pulse.
                r_posted <= 1'b0;
                r_state  <= S_IDLE;
              end else begin
                r_resp  <= 1'b1;
                r_state <= S_DONE;
              end
`else
              r_resp  <= 1'b1;
              r_state <= S_DONE;
`endif
            end
          end
        end

        S_DONE: begin
          // Single-cycle acknowledge; requests still high here are the old ones and are not re-accepted.
          r_resp <= 1'b0;
`ifdef CLA_POSTED_WRITE_EN
          if (r_posted) begin
            r_cnt   <= 2'd0;
            r_write <= 1'b1;
            r_state <= S_WRITE;
          end else begin
            r_state <= S_IDLE;
          end
`else
          r_state <= S_IDLE;
`endif
        end

        default: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_resp  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Testbench for cacheline_adaptor: table-driven per-cycle vectors plus hand-written multi-cycle sequences.
// Inputs change 1ns after the rising edge; outputs are compared at the same point, reflecting the edge just taken.
// Works with or without CLA_POSTED_WRITE_EN; expectations for writes follow the selected build.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  cacheline_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .burst_i      (burst_i),
    .burst_o      (burst_o),
    .address_o    (address_o),
    .read_o       (read_o),
    .write_o      (write_o),
    .resp_i       (resp_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        rsp;
    logic [31:0] addr;
    logic [63:0] beat;
    logic        e_rd;
    logic        e_wr;
    logic        e_resp;
    logic [31:0] e_addr;
    logic [63:0] e_bo;
  } vec_t;

  vec_t vq[$];

  localparam logic [63:0] BA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] BC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] BD = 64'hDDDD_DDDD_DDDD_DDDD;
  localparam logic [63:0] R1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] R2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] R3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] R4 = 64'h4444_4444_4444_4444;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rd, input logic wr, input logic rsp, input logic [31:0] addr,
                     input logic [63:0] beat, input logic e_rd, input logic e_wr, input logic e_resp,
                     input logic [31:0] e_addr, input logic [63:0] e_bo);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rsp = rsp; v.addr = addr; v.beat = beat;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp; v.e_addr = e_addr; v.e_bo = e_bo;
    vq.push_back(v);
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      pmem_read    = vq[i].rd;
      pmem_write   = vq[i].wr;
      resp_i       = vq[i].rsp;
      pmem_address = vq[i].addr;
      burst_i      = vq[i].beat;
      cyc();
      chk($sformatf("%s[%0d].read_o", tag, i),    {255'd0, read_o},    {255'd0, vq[i].e_rd});
      chk($sformatf("%s[%0d].write_o", tag, i),   {255'd0, write_o},   {255'd0, vq[i].e_wr});
      chk($sformatf("%s[%0d].pmem_resp", tag, i), {255'd0, pmem_resp}, {255'd0, vq[i].e_resp});
      chk($sformatf("%s[%0d].address_o", tag, i), {224'd0, address_o}, {224'd0, vq[i].e_addr});
      chk($sformatf("%s[%0d].burst_o", tag, i),   {192'd0, burst_o},   {192'd0, vq[i].e_bo});
    end
    vq.delete();
  endtask

  initial begin
    logic [255:0] line_a;
    logic [63:0]  nb[4];
    logic [63:0]  rb[4];
    int nresp, r1_cyc, first_rd, last_wr, nwr, rd_given;
    logic overlap;

    rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = 32'd0;
    pmem_wdata = 256'd0; burst_i = 64'd0; resp_i = 1'b0;
    cyc(); cyc();
    // Reset state
    chk("rst.pmem_rdata", pmem_rdata, 256'd0);
    chk("rst.pmem_resp", {255'd0, pmem_resp}, 256'd0);
    chk("rst.burst_o", {192'd0, burst_o}, 256'd0);
    chk("rst.address_o", {224'd0, address_o}, 256'd0);
    chk("rst.read_o", {255'd0, read_o}, 256'd0);
    chk("rst.write_o", {255'd0, write_o}, 256'd0);
    rst = 1'b0;
    cyc();

    // Fastest read of 0x1234, beats back-to-back from T+1
    add(1, 0, 0, 32'h1234, 64'd0, 1, 0, 0, 32'h1220, 64'd0);
    add(1, 0, 1, 32'h1234, R1,    1, 0, 0, 32'h1220, 64'd0);
    add(1, 0, 1, 32'h1234, R2,    1, 0, 0, 32'h1220, 64'd0);
    add(1, 0, 1, 32'h1234, R3,    1, 0, 0, 32'h1220, 64'd0);
    add(1, 0, 1, 32'h1234, R4,    0, 0, 1, 32'h1220, 64'd0);
    add(0, 0, 0, 32'h0,    64'd0, 0, 0, 0, 32'h1220, 64'd0);
    run_vectors("rd");
    chk("rd.pmem_rdata", pmem_rdata, {R4, R3, R2, R1});

    // Write with resp_i gaps 1,0,1,0,1,1
    pmem_wdata = {BD, BC, BB, BA};
`ifdef CLA_POSTED_WRITE_EN
    add(0, 1, 0, 32'h2ABC, 64'd0, 0, 0, 1, 32'h2AA0, BA);
    add(0, 0, 0, 32'h0,    64'd0, 0, 1, 0, 32'h2AA0, BA);
    add(0, 0, 1, 32'h0,    64'd0, 0, 1, 0, 32'h2AA0, BB);
    add(0, 0, 0, 32'h0,    64'd0, 0, 1, 0, 32'h2AA0, BB);
    add(0, 0, 1, 32'h0,    64'd0, 0, 1, 0, 32'h2AA0, BC);
    add(0, 0, 0, 32'h0,    64'd0, 0, 1, 0, 32'h2AA0, BC);
    add(0, 0, 1, 32'h0,    64'd0, 0, 1, 0, 32'h2AA0, BD);
    add(0, 0, 1, 32'h0,    64'd0, 0, 0, 0, 32'h2AA0, BA);
    add(0, 0, 0, 32'h0,    64'd0, 0, 0, 0, 32'h2AA0, BA);
`else
    add(0, 1, 0, 32'h2ABC, 64'd0, 0, 1, 0, 32'h2AA0, BA);
    add(0, 1, 1, 32'h2ABC, 64'd0, 0, 1, 0, 32'h2AA0, BB);
    add(0, 1, 0, 32'h2ABC, 64'd0, 0, 1, 0, 32'h2AA0, BB);
    add(0, 1, 1, 32'h2ABC, 64'd0, 0, 1, 0, 32'h2AA0, BC);
    add(0, 1, 0, 32'h2ABC, 64'd0, 0, 1, 0, 32'h2AA0, BC);
    add(0, 1, 1, 32'h2ABC, 64'd0, 0, 1, 0, 32'h2AA0, BD);
    add(0, 1, 1, 32'h2ABC, 64'd0, 0, 0, 1, 32'h2AA0, BA);
    add(0, 0, 0, 32'h0,    64'd0, 0, 0, 0, 32'h2AA0, BA);
`endif
    run_vectors("wr");
    chk("wr.pmem_rdata_kept", pmem_rdata, {R4, R3, R2, R1});

    // Read and write raised together: write wins, read_o stays low
`ifdef CLA_POSTED_WRITE_EN
    add(1, 1, 0, 32'h3000, 64'd0, 0, 0, 1, 32'h3000, BA);
    add(0, 0, 0, 32'h0,    64'd0, 0, 1, 0, 32'h3000, BA);
    add(0, 0, 1, 32'h0,    64'd0, 0, 1, 0, 32'h3000, BB);
    add(0, 0, 1, 32'h0,    64'd0, 0, 1, 0, 32'h3000, BC);
    add(0, 0, 1, 32'h0,    64'd0, 0, 1, 0, 32'h3000, BD);
    add(0, 0, 1, 32'h0,    64'd0, 0, 0, 0, 32'h3000, BA);
    add(0, 0, 0, 32'h0,    64'd0, 0, 0, 0, 32'h3000, BA);
`else
    add(1, 1, 0, 32'h3000, 64'd0, 0, 1, 0, 32'h3000, BA);
    add(1, 1, 1, 32'h3000, 64'd0, 0, 1, 0, 32'h3000, BB);
    add(1, 1, 1, 32'h3000, 64'd0, 0, 1, 0, 32'h3000, BC);
    add(1, 1, 1, 32'h3000, 64'd0, 0, 1, 0, 32'h3000, BD);
    add(1, 1, 1, 32'h3000, 64'd0, 0, 0, 1, 32'h3000, BA);
    add(0, 0, 0, 32'h0,    64'd0, 0, 0, 0, 32'h3000, BA);
`endif
    run_vectors("both");

    // Reset in the middle of a read after two beats
    pmem_read = 1'b1; pmem_address = 32'h1000; resp_i = 1'b0;
    cyc();
    resp_i = 1'b1; burst_i = 64'h5555_5555_5555_5555;
    cyc();
    burst_i = 64'h6666_6666_6666_6666;
    cyc();
    rst = 1'b1; pmem_read = 1'b0; resp_i = 1'b0;
    #1;
    chk("midrst.read_o", {255'd0, read_o}, 256'd0);
    chk("midrst.pmem_resp", {255'd0, pmem_resp}, 256'd0);
    chk("midrst.address_o", {224'd0, address_o}, 256'd0);
    chk("midrst.pmem_rdata", pmem_rdata, 256'd0);
    cyc();
    rst = 1'b0;
    nresp = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (pmem_resp || read_o) nresp++;
    end
    chk("midrst.quiet", 256'(nresp), 256'd0);

    // Fresh read of 0x1000 after the aborted one
    nb[0] = 64'hA1A1_A1A1_A1A1_A1A1; nb[1] = 64'hA2A2_A2A2_A2A2_A2A2;
    nb[2] = 64'hA3A3_A3A3_A3A3_A3A3; nb[3] = 64'hA4A4_A4A4_A4A4_A4A4;
    line_a = {nb[3], nb[2], nb[1], nb[0]};
    pmem_read = 1'b1; pmem_address = 32'h1000;
    cyc();
    chk("fresh.read_o", {255'd0, read_o}, 256'd1);
    chk("fresh.address_o", {224'd0, address_o}, 256'h1000);
    resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      burst_i = nb[k];
      cyc();
      if (k < 3) chk($sformatf("fresh.no_resp%0d", k), {255'd0, pmem_resp}, 256'd0);
    end
    chk("fresh.pmem_resp", {255'd0, pmem_resp}, 256'd1);
    chk("fresh.pmem_rdata", pmem_rdata, line_a);
    pmem_read = 1'b0; resp_i = 1'b0;
    cyc();
    chk("fresh.resp_drop", {255'd0, pmem_resp}, 256'd0);

    // Write-back then read-back; pmem_read rises in the write's DONE cycle; memory strobes every cycle
    rb[0] = 64'hB1B1_B1B1_B1B1_B1B1; rb[1] = 64'hB2B2_B2B2_B2B2_B2B2;
    rb[2] = 64'hB3B3_B3B3_B3B3_B3B3; rb[3] = 64'hB4B4_B4B4_B4B4_B4B4;
    nresp = 0; r1_cyc = -1; first_rd = -1; last_wr = -1; nwr = 0; rd_given = 0; overlap = 1'b0;
    pmem_wdata = {BA, BB, BC, BD};
    pmem_write = 1'b1; pmem_address = 32'h4000; resp_i = 1'b1; burst_i = 64'd0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (read_o && write_o) overlap = 1'b1;
      if (write_o) begin
        last_wr = i;
        nwr++;
      end
      if (read_o && first_rd < 0) begin
        first_rd = i;
        chk("b2b.rdata_before_read", pmem_rdata, line_a);
      end
      if (read_o && rd_given < 4) begin
        burst_i = rb[rd_given];
        rd_given++;
      end
      if (pmem_resp) begin
        nresp++;
        if (nresp == 1) begin
          r1_cyc = i;
          chk("b2b.rdata_after_write", pmem_rdata, line_a);
          pmem_write = 1'b0;
          pmem_read = 1'b1;
          pmem_address = 32'h5000;
        end else begin
          chk("b2b.rdata_read", pmem_rdata, {rb[3], rb[2], rb[1], rb[0]});
          pmem_read = 1'b0;
        end
      end
    end
    resp_i = 1'b0;
    chk("b2b.resp_count", 256'(nresp), 256'd2);
    chk("b2b.overlap", {255'd0, overlap}, 256'd0);
    chk("b2b.write_beats", 256'(nwr), 256'd4);
`ifdef CLA_POSTED_WRITE_EN
    chk("b2b.read_start", 256'(first_rd), 256'(last_wr + 2));
`else
    chk("b2b.read_start", 256'(first_rd), 256'(r1_cyc + 2));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Responder for the data cache's physical-memory port. Accepts a whole-line (256-bit) read or write request from the cache controller and executes it on main memory as a 4-beat, 64-bit burst. Returns a single-cycle `pmem_resp` when the line transfer is complete. Sits between the dcache and the memory arbiter/DRAM model.

## Interface
- No parameters. Line = 256 bits, beat = 64 bits, 4 beats per line.
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `pmem_read`  in  1  cache line-read request; held high until `pmem_resp`
- `pmem_write`  in  1  cache line-write request; held high until `pmem_resp`
- `pmem_address`  in  32  line address from cache; bits [4:0] ignored
- `pmem_wdata`  in  256  line to write; valid while `pmem_write` is high
- `pmem_rdata`  out  256  line read from memory; valid when `pmem_resp` is high after a read
- `pmem_resp`  out  1  one-cycle completion pulse to cache
- `burst_i`  in  64  read beat from memory
- `burst_o`  out  64  write beat to memory
- `address_o`  out  32  burst address, always `{pmem_address[31:5], 5'b0}` as latched
- `read_o`  out  1  burst read request to memory
- `write_o`  out  1  burst write request to memory
- `resp_i`  in  1  memory beat strobe: read data valid / write beat accepted

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On `pmem_write`, latch the address and `pmem_wdata` into the write buffer, then go to WRITE.
  - Else on `pmem_read`, latch the address, then go to READ.
  - If both are high, write wins. The cache never does this; it is defined for safety.
- READ:
  - `read_o=1`.
  - Each cycle with `resp_i=1`, store `burst_i` into `rbuf[64*cnt +: 64]` and increment the 2-bit `cnt`.
  - On the beat with `cnt==3`, go to DONE.
- WRITE:
  - `write_o=1`, `burst_o = wbuf[64*cnt +: 64]`.
  - Each `resp_i` increments `cnt`; the beat with `cnt==3` goes to DONE.
- DONE:
  - `pmem_resp=1` for exactly one cycle, then return to IDLE unconditionally.
  - Request inputs still high during DONE are not treated as a new request.
- Beat order: beat 0 = bits [63:0] through beat 3 = bits [255:192].
- `cnt` clears on entry to READ/WRITE and wraps 3->0.
- `pmem_rdata` is driven from `rbuf`. It holds the last completed read line and is unchanged by writes.
- `resp_i` in IDLE or DONE is ignored.
- Outputs `read_o`, `write_o`, `pmem_resp` are decoded from state only (Moore). There is no combinational path from inputs to outputs.
- `address_o` holds the latched aligned address from acceptance until the next acceptance.

## Timing
- Reset value of every output is 0: `pmem_rdata`, `pmem_resp`, `burst_o`, `address_o`, `read_o`, `write_o`. `rbuf`, `wbuf`, `cnt` and the address latch also clear to 0, and state goes to IDLE.
- Request seen in IDLE at cycle T: `read_o`/`write_o` high from T+1.
- Fastest read, with `resp_i` high T+1..T+4: `pmem_resp` at T+5, `pmem_rdata` valid at T+5, IDLE at T+6.
- Stalled memory: `resp_i` gaps simply hold `cnt`. There is no timeout.
- The next request can be accepted at T+6, the cycle after `pmem_resp`. This matches the cache's write-back -> read-back back-to-back sequence.
- `rst` asserted mid-burst: immediately returns to IDLE, drops `read_o`/`write_o`, discards partial data, and never issues `pmem_resp`.

## Configuration
- `CLA_POSTED_WRITE_EN`
- Defined:
  - A write is acknowledged without waiting for memory. IDLE latches `wbuf` and goes to DONE, so `pmem_resp` comes at T+1.
  - DONE then enters WRITE with a posted flag set, and the burst runs in the background.
  - At the 4th `resp_i` of a posted write, go straight to IDLE with no second `pmem_resp`.
  - Requests arriving during a posted burst wait. They are accepted in IDLE after the burst completes, so a read following a posted write sees its data in memory.
- Undefined: writes complete as in Operation, with `pmem_resp` one cycle after the 4th `resp_i`.

## Test plan
- Reset mid-READ after 2 beats -> outputs 0, no `pmem_resp`. A fresh read of 0x0000_1000 then completes normally with 4 new beats.
- Read 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back from T+1 -> `address_o`=0x0000_1220, `pmem_resp` at T+5, `pmem_rdata`={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write `pmem_wdata`={0xD..D,0xC..C,0xB..B,0xA..A} with `resp_i` gaps (1,0,1,0,1,1) -> `burst_o` sequence A,B,C,D. `pmem_resp` one cycle after the 4th strobe, or at T+1 with `CLA_POSTED_WRITE_EN`.
- Write-back immediately followed by read, `pmem_read` rising in the DONE cycle -> exactly two `pmem_resp` pulses. The read burst starts the cycle after IDLE. `pmem_rdata` is unchanged by the write.
- `pmem_read` and `pmem_write` both high -> `write_o` asserted, `read_o` stays 0.
- `CLA_POSTED_WRITE_EN`: write then read issued during the posted burst -> `read_o` is not asserted until the write's 4th `resp_i` plus one IDLE cycle.
